// File: rtl/uart_boot_loader.sv
// Purpose : UART serial boot loader; packs received bytes big-endian into 32-bit words and writes them to RAM over Wishbone.
// Latency : a byte is valid 3 cycles after its stop bit reaches uart_rx; a write request is driven 2 cycles after the word's 4th byte.
// Backpr. : wb_stall holds the request stable; a 2-word buffer absorbs slow acks, and a word arriving while it is full is dropped with ovf_err.
//
// Ports:
//   sys_clk, sys_rst           clock, asynchronous active-high reset
//   uart_rx                    serial input, idle high, 8 data bits MSB first
//   wb_cyc/stb/we/be/addr/data_o  Wishbone master write request (all registered)
//   wb_ack, wb_stall           Wishbone slave responses
//   boot_done                  sticky, WORD_COUNT words acknowledged
//   frame_err, ovf_err         sticky error flags
//   word_cnt                   words acknowledged so far
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned WORD_COUNT   = 1024,
    localparam int unsigned CNT_W       = $clog2(WORD_COUNT + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             uart_rx,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [3:0]       wb_be,
    output logic [31:0]      wb_addr,
    output logic [31:0]      wb_data_o,
    input  logic             wb_ack,
    input  logic             wb_stall,
    output logic             boot_done,
    output logic             frame_err,
    output logic             ovf_err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [15:0]      BIT_LEN  = 16'(CLKS_PER_BIT);
    localparam logic [15:0]      HALF_LEN = 16'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] WC_LAST  = CNT_W'(WORD_COUNT);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_ACK} wr_state_t;

    // Receiver state
    rx_state_t   r_rx_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx_shift;
    logic        r_byte_vld;
    logic        r_frame_err;

    // Packer and word buffer state
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word_hi;
    logic [29:0] r_wr_idx;
    logic [31:0] r_fifo_addr [0:1];
    logic [31:0] r_fifo_data [0:1];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_fifo_cnt;
    logic        r_ovf_err;

    // Write master state
    wr_state_t        r_wr_state;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_boot_done;

    logic        w_cnt_full;
    logic        w_done;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push_ok;
    logic [31:0] w_push_addr;

    // The final count blocks new work immediately, one cycle before boot_done is visible.
    assign w_cnt_full  = (r_word_cnt == WC_LAST);
    assign w_done      = r_boot_done | w_cnt_full;
    assign w_pop       = ((r_wr_state == W_REQ) && !wb_stall && wb_ack) ||
                         ((r_wr_state == W_ACK) && wb_ack);
    assign w_push_req  = r_byte_vld && !w_done && (r_byte_idx == 2'd3);
    // A pop in the same cycle frees a slot, so a push into a full buffer still fits.
    assign w_push_ok   = w_push_req && ((r_fifo_cnt != 2'd2) || w_pop);
    assign w_push_addr = BASE_ADDR + {r_wr_idx, 2'b00};

    assign wb_cyc    = r_cyc;
    assign wb_stb    = r_stb;
    assign wb_we     = r_we;
    assign wb_be     = r_be;
    assign wb_addr   = r_addr;
    assign wb_data_o = r_data;
    assign boot_done = r_boot_done;
    assign frame_err = r_frame_err;
    assign ovf_err   = r_ovf_err;
    assign word_cnt  = r_word_cnt;

    // Receiver: synchroniser plus bit-timing FSM. r_clk_cnt counts from 1 at each bit boundary.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_state  <= R_IDLE;
            r_clk_cnt   <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_s     <= r_rx_meta;
            r_byte_vld <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (!r_rx_s) begin
                        r_bit_cnt <= 3'd0;
                        r_clk_cnt <= 16'd1;
                        // With a one-cycle bit the detecting sample already is the mid-bit sample.
                        r_rx_state <= (HALF_LEN == 16'd0) ? R_DATA : R_START;
                    end
                end
                R_START: begin
                    if (r_clk_cnt == HALF_LEN) begin
                        r_clk_cnt  <= 16'd1;
                        r_rx_state <= r_rx_s ? R_IDLE : R_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == BIT_LEN) begin
                        r_clk_cnt  <= 16'd1;
                        r_rx_shift <= {r_rx_shift[6:0], r_rx_s};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                R_STOP: begin
                    if (r_clk_cnt == BIT_LEN) begin
                        if (r_rx_s) begin
                            r_byte_vld <= 1'b1;
                        end else if (!w_done) begin
                            r_frame_err <= 1'b1;
                        end
                        r_rx_state <= R_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // Packer and 2-entry word buffer. A dropped word still advances the address index.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_byte_idx     <= 2'd0;
            r_word_hi      <= 24'd0;
            r_wr_idx       <= 30'd0;
            r_fifo_addr[0] <= 32'd0;
            r_fifo_addr[1] <= 32'd0;
            r_fifo_data[0] <= 32'd0;
            r_fifo_data[1] <= 32'd0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_fifo_cnt     <= 2'd0;
            r_ovf_err      <= 1'b0;
        end else begin
            if (r_byte_vld && !w_done) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_word_hi[23:16] <= r_rx_shift;
                    2'd1: r_word_hi[15:8]  <= r_rx_shift;
                    2'd2: r_word_hi[7:0]   <= r_rx_shift;
                    default: begin
                        r_wr_idx <= r_wr_idx + 30'd1;
                        // When full, the slot overwritten is the head being popped; its
                        // contents already sit in the Wishbone output registers.
                        if (w_push_ok) begin
                            r_fifo_addr[r_wptr] <= w_push_addr;
                            r_fifo_data[r_wptr] <= {r_word_hi, r_rx_shift};
                            r_wptr              <= ~r_wptr;
                        end else begin
                            r_ovf_err <= 1'b1;
                        end
                    end
                endcase
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Wishbone write master: one outstanding write, head popped only on ack.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_state  <= W_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_word_cnt  <= '0;
            r_boot_done <= 1'b0;
        end else begin
            r_boot_done <= r_boot_done | w_cnt_full;
            case (r_wr_state)
                W_IDLE: begin
                    if ((r_fifo_cnt != 2'd0) && !w_done) begin
                        r_cyc      <= 1'b1;
                        r_stb      <= 1'b1;
                        r_we       <= 1'b1;
                        r_be       <= 4'hF;
                        r_addr     <= r_fifo_addr[r_rptr];
                        r_data     <= r_fifo_data[r_rptr];
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (!wb_stall) begin
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (wb_ack) begin
                            r_cyc      <= 1'b0;
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                            r_wr_state <= W_IDLE;
                        end else begin
                            r_wr_state <= W_ACK;
                        end
                    end
                end
                W_ACK: begin
                    if (wb_ack) begin
                        r_cyc      <= 1'b0;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: instance A runs one clock per bit with a
// two-word boot image, instance B runs eight clocks per bit.
module tb_uart_boot_loader;

    localparam logic [31:0] BASE_A = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rx_a, ack_a, stall_a, cyc_a, stb_a, we_a, done_a, ferr_a, ovf_a;
    logic [3:0]  be_a;
    logic [31:0] addr_a, data_a;
    logic [1:0]  wcnt_a;

    logic        rx_b, ack_b, stall_b, cyc_b, stb_b, we_b, done_b, ferr_b, ovf_b;
    logic [3:0]  be_b;
    logic [31:0] addr_b, data_b;
    logic [2:0]  wcnt_b;

    uart_boot_loader #(.CLKS_PER_BIT(1), .BASE_ADDR(BASE_A), .WORD_COUNT(2)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(rx_a),
        .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_we(we_a), .wb_be(be_a),
        .wb_addr(addr_a), .wb_data_o(data_a), .wb_ack(ack_a), .wb_stall(stall_a),
        .boot_done(done_a), .frame_err(ferr_a), .ovf_err(ovf_a), .word_cnt(wcnt_a)
    );

    uart_boot_loader #(.CLKS_PER_BIT(8), .BASE_ADDR(32'h0), .WORD_COUNT(4)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .uart_rx(rx_b),
        .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_we(we_b), .wb_be(be_b),
        .wb_addr(addr_b), .wb_data_o(data_b), .wb_ack(ack_b), .wb_stall(stall_b),
        .boot_done(done_b), .frame_err(ferr_b), .ovf_err(ovf_b), .word_cnt(wcnt_b)
    );

    int checks = 0;
    int errors = 0;
    int bad_be = 0;
    int stall_req = 0;
    int stall_seen = 0;
    int hold_bad = 0;
    bit ack_en = 1'b1;
    bit owe_a = 1'b0;
    bit owe_b = 1'b0;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] log_b_addr[$];
    logic [31:0] log_b_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] la(input int i);
        if (i < log_addr.size()) return log_addr[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ld(input int i);
        if (i < log_data.size()) return log_data[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] lbd(input int i);
        if (i < log_b_data.size()) return log_b_data[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] lba(input int i);
        if (i < log_b_addr.size()) return log_b_addr[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Slave A: optional stall count on the next request, ack one cycle after acceptance when enabled.
    initial begin
        ack_a = 1'b0;
        stall_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ack_a = 1'b0;
                stall_a = 1'b0;
                owe_a = 1'b0;
            end else begin
                ack_a = 1'b0;
                if (owe_a && ack_en) begin
                    ack_a = 1'b1;
                    owe_a = 1'b0;
                end
                stall_a = 1'b0;
                if (stb_a) begin
                    if (we_a !== 1'b1 || be_a !== 4'hF) bad_be++;
                    if (stall_req > 0) begin
                        if (stall_seen == 0) begin
                            hold_addr = addr_a;
                            hold_data = data_a;
                        end else if (addr_a !== hold_addr || data_a !== hold_data) begin
                            hold_bad++;
                        end
                        stall_a = 1'b1;
                        stall_req--;
                        stall_seen++;
                    end else begin
                        log_addr.push_back(addr_a);
                        log_data.push_back(data_a);
                        owe_a = 1'b1;
                    end
                end
            end
        end
    end

    // Slave B: never stalls, acks the cycle after acceptance.
    initial begin
        ack_b = 1'b0;
        stall_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_b = owe_b && !rst;
            owe_b = 1'b0;
            if (stb_b && !rst) begin
                log_b_addr.push_back(addr_b);
                log_b_data.push_back(data_b);
                owe_b = 1'b1;
            end
        end
    end

    task automatic drive_rx(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit sel_b, input logic [7:0] b, input logic stop);
        int len;
        logic [9:0] fr;
        len = sel_b ? 8 : 1;
        fr = {1'b0, b, stop};
        for (int i = 9; i >= 0; i--) begin
            @(posedge clk);
            #1;
            drive_rx(sel_b, fr[i]);
            repeat (len - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        drive_rx(sel_b, 1'b1);
        repeat (len) @(posedge clk);
    endtask

    task automatic send_word(input bit sel_b, input logic [31:0] w);
        send(sel_b, w[31:24], 1'b1);
        send(sel_b, w[23:16], 1'b1);
        send(sel_b, w[15:8], 1'b1);
        send(sel_b, w[7:0], 1'b1);
    endtask

    task automatic wait_log(input bit sel_b, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (((sel_b ? log_b_addr.size() : log_addr.size()) < n) && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(tag, 32'(sel_b ? log_b_addr.size() : log_addr.size()), 32'(n));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        log_addr.delete();
        log_data.delete();
        ack_en = 1'b1;
        stall_req = 0;
        stall_seen = 0;
        hold_bad = 0;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        wait_cycles(3);
        check("rst_cyc", 32'(cyc_a), 32'd0);
        check("rst_stb", 32'(stb_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_be", 32'(be_a), 32'd0);
        check("rst_addr", addr_a, 32'd0);
        check("rst_data", data_a, 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_wcnt", 32'(wcnt_a), 32'd0);
        check("rst_cyc_b", 32'(cyc_b), 32'd0);
        do_reset();

        // Single word, immediate ack
        send_word(1'b0, 32'hDEADBEEF);
        wait_log(1'b0, 1, 60, "t1_nwrites");
        check("t1_addr", la(0), BASE_A);
        check("t1_data", ld(0), 32'hDEADBEEF);
        wait_cycles(4);
        check("t1_wcnt", 32'(wcnt_a), 32'd1);
        check("t1_cyc_idle", 32'(cyc_a), 32'd0);
        check("t1_done", 32'(done_a), 32'd0);

        // Two words, first stalled for 5 cycles; second reaches WORD_COUNT
        do_reset();
        stall_req = 5;
        send_word(1'b0, 32'h01020304);
        send_word(1'b0, 32'h05060708);
        wait_log(1'b0, 2, 100, "t2_nwrites");
        check("t2_stall_cycles", 32'(stall_seen), 32'd5);
        check("t2_hold_bad", 32'(hold_bad), 32'd0);
        check("t2_addr0", la(0), BASE_A);
        check("t2_data0", ld(0), 32'h01020304);
        check("t2_addr1", la(1), BASE_A + 32'd4);
        check("t2_data1", ld(1), 32'h05060708);
        for (int k = 0; k < 10 && wcnt_a != 2'd2; k++) begin
            @(posedge clk);
            #2;
        end
        check("t2_wcnt", 32'(wcnt_a), 32'd2);
        check("t2_done_lag", 32'(done_a), 32'd0);
        wait_cycles(1);
        check("t2_done", 32'(done_a), 32'd1);

        // After boot_done: bytes and bad frames are ignored
        send_word(1'b0, 32'h090A0B0C);
        send(1'b0, 8'h77, 1'b0);
        wait_cycles(20);
        check("t5_nwrites", 32'(log_addr.size()), 32'd2);
        check("t5_wcnt", 32'(wcnt_a), 32'd2);
        check("t5_ovf", 32'(ovf_a), 32'd0);
        check("t5_ferr", 32'(ferr_a), 32'd0);
        check("t5_cyc", 32'(cyc_a), 32'd0);

        // Bad stop bit discards its byte
        do_reset();
        send(1'b0, 8'h55, 1'b0);
        wait_cycles(4);
        check("t3_ferr", 32'(ferr_a), 32'd1);
        send_word(1'b0, 32'h11223344);
        wait_log(1'b0, 1, 60, "t3_nwrites");
        check("t3_addr", la(0), BASE_A);
        check("t3_data", ld(0), 32'h11223344);
        wait_cycles(4);
        check("t3_wcnt", 32'(wcnt_a), 32'd1);
        check("t3_ovf", 32'(ovf_a), 32'd0);

        // Ack withheld: two words buffered, third dropped
        do_reset();
        ack_en = 1'b0;
        send_word(1'b0, 32'h10111213);
        send_word(1'b0, 32'h20212223);
        send_word(1'b0, 32'h30313233);
        wait_cycles(6);
        check("t4_ovf", 32'(ovf_a), 32'd1);
        check("t4_nreq", 32'(log_addr.size()), 32'd1);
        check("t4_cyc_held", 32'(cyc_a), 32'd1);
        check("t4_wcnt0", 32'(wcnt_a), 32'd0);
        check("t4_data0", ld(0), 32'h10111213);
        ack_en = 1'b1;
        wait_log(1'b0, 2, 40, "t4_nwrites");
        check("t4_addr1", la(1), BASE_A + 32'd4);
        check("t4_data1", ld(1), 32'h20212223);
        wait_cycles(30);
        check("t4_wcnt", 32'(wcnt_a), 32'd2);
        check("t4_nwrites_final", 32'(log_addr.size()), 32'd2);

        // Asynchronous reset mid-write and mid-frame
        do_reset();
        ack_en = 1'b0;
        send_word(1'b0, 32'hCAFEF00D);
        wait_log(1'b0, 1, 60, "t6_nreq");
        check("t6_cyc_before", 32'(cyc_a), 32'd1);
        send(1'b0, 8'h99, 1'b1);
        send(1'b0, 8'h88, 1'b1);
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_cyc", 32'(cyc_a), 32'd0);
        check("t6_stb", 32'(stb_a), 32'd0);
        check("t6_be", 32'(be_a), 32'd0);
        check("t6_addr", addr_a, 32'd0);
        check("t6_data", data_a, 32'd0);
        check("t6_wcnt", 32'(wcnt_a), 32'd0);
        do_reset();
        send_word(1'b0, 32'h12345678);
        wait_log(1'b0, 1, 60, "t6_nwrites");
        check("t6_addr_restart", la(0), BASE_A);
        check("t6_data_restart", ld(0), 32'h12345678);

        // Eight clocks per bit: start glitch rejected, then a clean word
        @(posedge clk);
        #1 rx_b = 1'b0;
        @(posedge clk);
        #1 rx_b = 1'b1;
        wait_cycles(40);
        check("t7_no_write", 32'(log_b_addr.size()), 32'd0);
        send_word(1'b1, 32'hA5112233);
        wait_log(1'b1, 1, 100, "t7_nwrites");
        check("t7_addr", lba(0), 32'h0);
        check("t7_data", lbd(0), 32'hA5112233);
        wait_cycles(4);
        check("t7_ferr", 32'(ferr_b), 32'd0);
        check("t7_wcnt", 32'(wcnt_b), 32'd1);

        check("we_be_during_stb", 32'(bad_be), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
